// File: rtl/vga_defs_pkg.sv
// vga_defs: definitions shared by the VGA display blocks.
//   H_VISIBLE / V_VISIBLE : visible area of the 640x480 timing.
//   ST_*                  : message_sequencer state encodings. They are plain
//                           2-bit constants so older blocks that compare raw
//                           codes keep working.
//   max_int               : elaboration-time helper for sizing counters.
package vga_defs;

    localparam int H_VISIBLE = 640;
    localparam int V_VISIBLE = 480;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SHOW = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/message_sequencer_frame_tick_gen.sv
// frame_tick_gen: one-cycle pulse at the start of vertical blank.
//   clk, rst_n  : system clock, asynchronous active-low reset
//   hcnt, vcnt  : VGA pixel / line counters
//   frame_tick  : registered pulse, high for exactly one clk cycle per frame
// The pixel clock may be slower than clk, so hcnt can sit at 0 on the first
// blank line for several clk cycles. Only the rising edge of the match
// produces a pulse.
module frame_tick_gen
    import vga_defs::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] hcnt,
    input  logic [10:0] vcnt,
    output logic        frame_tick
);

    logic match;
    logic match_q;

    assign match = (hcnt == 11'd0) && (vcnt == 11'(V_VISIBLE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_q    <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            match_q    <= match;
            frame_tick <= match & ~match_q;
        end
    end

endmodule

// File: rtl/message_sequencer.sv
// message_sequencer: chooses which stored message string_display renders.
// Each message is shown for SHOW_FRAMES frames, with a horizontal scroll
// that advances once per frame, then blanked for GAP_FRAMES frames. All
// state changes happen one cycle after frame_tick, at the start of vertical
// blank, so a frame never shows a mix of old and new settings.
//   clk, rst_n  : system clock, asynchronous active-low reset
//   hcnt, vcnt  : VGA counters, used only to find the frame boundary
//   run         : level; 0 sends the block to IDLE at the next frame
//   skip        : one-cycle pulse; jump to the next message at the next frame
//   msg_sel     : message index for string_display
//   disp_enable : enable for string_display (high while a message is shown)
//   x_offset    : horizontal scroll offset, 0..H_VISIBLE-1
//   frame_tick  : one-cycle frame boundary pulse
module message_sequencer
    import vga_defs::*;
#(
    parameter int NUM_MSGS    = 4,
    parameter int MSG_W       = 3,
    parameter int SHOW_FRAMES = 180,
    parameter int GAP_FRAMES  = 30,
    parameter int SCROLL_STEP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [10:0]      hcnt,
    input  logic [10:0]      vcnt,
    input  logic             run,
    input  logic             skip,
    output logic [MSG_W-1:0] msg_sel,
    output logic             disp_enable,
    output logic [10:0]      x_offset,
    output logic             frame_tick
);

    localparam int CNT_MAX = max_int(SHOW_FRAMES, GAP_FRAMES);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    logic [1:0]       state;
    logic [CNT_W-1:0] frame_cnt;
    logic             skip_pend;
    logic [MSG_W-1:0] msg_next;
    logic [11:0]      x_sum;
    logic [10:0]      x_adv;
    logic             show_done;
    logic             gap_done;

    frame_tick_gen u_frame_tick_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .hcnt       (hcnt),
        .vcnt       (vcnt),
        .frame_tick (frame_tick)
    );

    assign msg_next  = (msg_sel == MSG_W'(NUM_MSGS - 1)) ? '0 : msg_sel + 1'b1;
    assign show_done = (frame_cnt == CNT_W'(SHOW_FRAMES - 1));
    assign gap_done  = (frame_cnt == CNT_W'(GAP_FRAMES - 1));

    // Scroll sum carries one extra bit so x_offset + step never overflows
    // before the wrap back into the visible range.
    assign x_sum = {1'b0, x_offset} + 12'(SCROLL_STEP);

    always_comb begin
        x_adv = x_sum[10:0];
        if (x_sum >= 12'(H_VISIBLE)) begin
            x_adv = 11'(x_sum - 12'(H_VISIBLE));
        end
    end

    // Skip latch. A skip landing on the tick cycle itself is kept for the
    // following tick: the set has priority over the consume-clear, while the
    // transition below uses the value latched before this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skip_pend <= 1'b0;
        end else if ((state == ST_IDLE) || (frame_tick && !run)) begin
            skip_pend <= 1'b0;
        end else if (skip) begin
            skip_pend <= 1'b1;
        end else if (frame_tick) begin
            skip_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            frame_cnt   <= '0;
            msg_sel     <= '0;
            disp_enable <= 1'b0;
            x_offset    <= '0;
        end else if (frame_tick) begin
            if (!run) begin
                state       <= ST_IDLE;
                frame_cnt   <= '0;
                msg_sel     <= '0;
                disp_enable <= 1'b0;
                x_offset    <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state       <= ST_SHOW;
                        frame_cnt   <= '0;
                        msg_sel     <= '0;
                        disp_enable <= 1'b1;
                        x_offset    <= '0;
                    end
                    ST_SHOW, ST_GAP: begin
                        if (skip_pend || ((state == ST_GAP) && gap_done)) begin
                            state       <= ST_SHOW;
                            frame_cnt   <= '0;
                            msg_sel     <= msg_next;
                            disp_enable <= 1'b1;
                            x_offset    <= '0;
                        end else if ((state == ST_SHOW) && show_done) begin
                            // x_offset holds its last value through the gap
                            state       <= ST_GAP;
                            frame_cnt   <= '0;
                            disp_enable <= 1'b0;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                            if (state == ST_SHOW) begin
                                x_offset <= x_adv;
                            end
                        end
                    end
                    default: begin
                        // unused encoding: recover to IDLE
                        state       <= ST_IDLE;
                        frame_cnt   <= '0;
                        msg_sel     <= '0;
                        disp_enable <= 1'b0;
                        x_offset    <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_message_sequencer.sv
// Bench for message_sequencer. Two instances share the VGA counters:
//   dut1: NUM_MSGS=3, SHOW_FRAMES=3, GAP_FRAMES=2, SCROLL_STEP=300
//   dut2: same but SHOW_FRAMES=4, used for the scroll wrap 0,300,600,260
// Each do_frame call pushes the hand-computed outputs expected after that
// frame's tick; one monitor per DUT pops and compares one cycle after it
// sees frame_tick.
module tb_message_sequencer;

    logic        clk;
    logic        rst_n;
    logic [10:0] hcnt;
    logic [10:0] vcnt;
    logic        run;
    logic        skip;
    logic        run2;
    logic        skip2;

    logic [2:0]  msg_sel1;
    logic        disp_enable1;
    logic [10:0] x_offset1;
    logic        frame_tick1;
    logic [2:0]  msg_sel2;
    logic        disp_enable2;
    logic [10:0] x_offset2;
    logic        frame_tick2;

    logic [14:0] exp_q[$];
    logic [14:0] exp2_q[$];

    int n_checks;
    int n_errors;

    message_sequencer #(
        .NUM_MSGS(3), .MSG_W(3), .SHOW_FRAMES(3), .GAP_FRAMES(2), .SCROLL_STEP(300)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .hcnt(hcnt), .vcnt(vcnt), .run(run), .skip(skip),
        .msg_sel(msg_sel1), .disp_enable(disp_enable1), .x_offset(x_offset1),
        .frame_tick(frame_tick1)
    );

    message_sequencer #(
        .NUM_MSGS(3), .MSG_W(3), .SHOW_FRAMES(4), .GAP_FRAMES(2), .SCROLL_STEP(300)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .hcnt(hcnt), .vcnt(vcnt), .run(run2), .skip(skip2),
        .msg_sel(msg_sel2), .disp_enable(disp_enable2), .x_offset(x_offset2),
        .frame_tick(frame_tick2)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    function automatic logic [14:0] ev(input int m, input int e, input int x);
        return {3'(m), 1'(e), 11'(x)};
    endfunction

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, expv);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_msg1"}, int'(msg_sel1), 0);
        check({name, "_en1"},  int'(disp_enable1), 0);
        check({name, "_x1"},   int'(x_offset1), 0);
        check({name, "_en2"},  int'(disp_enable2), 0);
        check({name, "_x2"},   int'(x_offset2), 0);
    endtask

    // ---------------- driver ----------------
    // Starts on a negedge. Holds the match position for 'hold' cycles, then
    // 8 body cycles that never match (hcnt=0 with vcnt!=480 on even cycles,
    // vcnt=480 with hcnt!=0 on odd ones). skm bit b pulses skip on body
    // cycle b; with hold=1, body cycle 0 coincides with the tick. rgm bit b
    // inverts run on body cycle b. The tick must appear exactly once, at the
    // first sample after the first match cycle (c=0).
    task automatic do_frame(input logic r, input logic r2, input int hold,
                            input logic [7:0] skm, input logic [7:0] rgm,
                            input logic [14:0] e1, input logic [14:0] e2);
        int nt;
        int at;
        int b;
        exp_q.push_back(e1);
        exp2_q.push_back(e2);
        nt   = 0;
        at   = -1;
        run  = r;
        run2 = r2;
        skip = 1'b0;
        hcnt = 11'd0;
        vcnt = 11'd480;
        for (int c = 0; c < hold + 8; c++) begin
            @(negedge clk);
            if (frame_tick1) begin
                nt++;
                if (at < 0) at = c;
            end
            b = c + 1 - hold;
            if (b >= 0 && b < 8) begin
                hcnt = (b % 2 == 0) ? 11'd0 : 11'(b);
                vcnt = (b % 2 == 0) ? 11'(b + 1) : 11'd480;
                skip = skm[b];
                run  = rgm[b] ? ~r : r;
            end else if (b >= 8) begin
                skip = 1'b0;
                run  = r;
            end
        end
        check("tick_count", nt, 1);
        check("tick_cycle", at, 0);
    endtask

    // ---------------- monitors / scoreboard ----------------
    initial begin
        logic [14:0] act;
        logic [14:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && frame_tick1) begin
                @(negedge clk);
                act = {msg_sel1, disp_enable1, x_offset1};
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL sb1_unexpected_tick: got msg=%0d en=%0d x=%0d, required no tick",
                             act[14:12], act[11], act[10:0]);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        n_errors++;
                        $display("FAIL sb1_outputs: got msg=%0d en=%0d x=%0d, required msg=%0d en=%0d x=%0d",
                                 act[14:12], act[11], act[10:0], e[14:12], e[11], e[10:0]);
                    end
                end
            end
        end
    end

    initial begin
        logic [14:0] act;
        logic [14:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && frame_tick2) begin
                @(negedge clk);
                act = {msg_sel2, disp_enable2, x_offset2};
                n_checks++;
                if (exp2_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL sb2_unexpected_tick: got msg=%0d en=%0d x=%0d, required no tick",
                             act[14:12], act[11], act[10:0]);
                end else begin
                    e = exp2_q.pop_front();
                    if (act !== e) begin
                        n_errors++;
                        $display("FAIL sb2_outputs: got msg=%0d en=%0d x=%0d, required msg=%0d en=%0d x=%0d",
                                 act[14:12], act[11], act[10:0], e[14:12], e[11], e[10:0]);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        hcnt  = 11'd5;
        vcnt  = 11'd5;
        run   = 1'b0;
        skip  = 1'b0;
        run2  = 1'b0;
        skip2 = 1'b0;

        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        check("reset_tick", int'(frame_tick1), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // frame tick with match held for 4 cycles, block idle
        do_frame(0, 0, 4, 8'h00, 8'h00, ev(0,0,0),   ev(0,0,0));
        // full cycle; dut2 shows its 4-frame scroll wrap
        do_frame(1, 1, 1, 8'h00, 8'h00, ev(0,1,0),   ev(0,1,0));
        do_frame(1, 1, 1, 8'h00, 8'h00, ev(0,1,300), ev(0,1,300));
        do_frame(1, 1, 1, 8'h00, 8'h00, ev(0,1,600), ev(0,1,600));
        do_frame(1, 1, 1, 8'h00, 8'h00, ev(0,0,600), ev(0,1,260));
        do_frame(1, 1, 1, 8'h00, 8'h00, ev(0,0,600), ev(0,0,260));
        do_frame(1, 0, 1, 8'h00, 8'h00, ev(1,1,0),   ev(0,0,0));
        do_frame(1, 0, 1, 8'h00, 8'h00, ev(1,1,300), ev(0,0,0));
        do_frame(1, 0, 1, 8'h00, 8'h00, ev(1,1,600), ev(0,0,0));
        do_frame(1, 0, 1, 8'h00, 8'h00, ev(1,0,600), ev(0,0,0));
        do_frame(1, 0, 1, 8'h00, 8'h00, ev(1,0,600), ev(0,0,0));
        do_frame(1, 0, 1, 8'h00, 8'h00, ev(2,1,0),   ev(0,0,0));
        do_frame(1, 0, 1, 8'h00, 8'h00, ev(2,1,300), ev(0,0,0));
        do_frame(1, 0, 1, 8'h00, 8'h00, ev(2,1,600), ev(0,0,0));
        do_frame(1, 0, 1, 8'h00, 8'h00, ev(2,0,600), ev(0,0,0));
        do_frame(1, 0, 1, 8'h00, 8'h00, ev(2,0,600), ev(0,0,0));
        do_frame(1, 0, 1, 8'h00, 8'h00, ev(0,1,0),   ev(0,0,0));
        do_frame(1, 0, 1, 8'h00, 8'h00, ev(0,1,300), ev(0,0,0));
        do_frame(1, 0, 1, 8'h00, 8'h00, ev(0,1,600), ev(0,0,0));
        do_frame(1, 0, 1, 8'h00, 8'h00, ev(0,0,600), ev(0,0,0));
        do_frame(1, 0, 1, 8'h00, 8'h00, ev(0,0,600), ev(0,0,0));
        // first frame of msg 1 with a skip, then two skips in one frame
        do_frame(1, 0, 1, 8'h04, 8'h00, ev(1,1,0),   ev(0,0,0));
        do_frame(1, 0, 1, 8'h24, 8'h00, ev(2,1,0),   ev(0,0,0));
        do_frame(1, 0, 1, 8'h00, 8'h00, ev(0,1,0),   ev(0,0,0));
        do_frame(1, 0, 1, 8'h00, 8'h00, ev(0,1,300), ev(0,0,0));
        // skip on the tick cycle is held over to the next tick
        do_frame(1, 0, 1, 8'h01, 8'h00, ev(0,1,600), ev(0,0,0));
        do_frame(1, 0, 1, 8'h00, 8'h00, ev(1,1,0),   ev(0,0,0));
        do_frame(1, 0, 1, 8'h00, 8'h00, ev(1,1,300), ev(0,0,0));
        do_frame(1, 0, 1, 8'h00, 8'h00, ev(1,1,600), ev(0,0,0));
        // skip during GAP
        do_frame(1, 0, 1, 8'h04, 8'h00, ev(1,0,600), ev(0,0,0));
        do_frame(1, 0, 1, 8'h00, 8'h00, ev(2,1,0),   ev(0,0,0));
        do_frame(1, 0, 1, 8'h00, 8'h00, ev(2,1,300), ev(0,0,0));
        do_frame(1, 0, 1, 8'h00, 8'h00, ev(2,1,600), ev(0,0,0));
        do_frame(1, 0, 1, 8'h00, 8'h00, ev(2,0,600), ev(0,0,0));
        // run dropped during GAP; skip in IDLE is discarded
        do_frame(0, 0, 1, 8'h00, 8'h00, ev(0,0,0),   ev(0,0,0));
        do_frame(0, 0, 1, 8'h04, 8'h00, ev(0,0,0),   ev(0,0,0));
        do_frame(1, 0, 1, 8'h00, 8'h00, ev(0,1,0),   ev(0,0,0));
        // run glitches low between ticks with no effect
        do_frame(1, 0, 1, 8'h00, 8'h1c, ev(0,1,300), ev(0,0,0));
        do_frame(1, 0, 1, 8'h00, 8'h00, ev(0,1,600), ev(0,0,0));

        // asynchronous reset mid-SHOW, between clock edges
        check("pre_reset_en", int'(disp_enable1), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        hcnt = 11'd0;
        vcnt = 11'd480;
        repeat (2) @(negedge clk);
        hcnt = 11'd9;
        vcnt = 11'd9;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_reset_tick", int'(frame_tick1), 0);
            check("post_reset_en",   int'(disp_enable1), 0);
        end
        do_frame(1, 0, 1, 8'h00, 8'h00, ev(0,1,0),   ev(0,0,0));
        do_frame(1, 0, 1, 8'h00, 8'h00, ev(0,1,300), ev(0,0,0));

        repeat (4) @(negedge clk);
        check("sb1_leftover", exp_q.size(), 0);
        check("sb2_leftover", exp2_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
